// File: rtl/snake_body_ctrl.sv
// Snake body controller: owns the segment list, steps it one cell per move tick,
// grows it on apple eat events, detects wall/self collisions and runs the
// IDLE/PLAY/DEAD game state.
// Ports:
//   CLK_50M, RSTn        - system clock, asynchronous active-low reset
//   key_up/down/left/right - debounced direction keys (level, active high)
//   add_cube             - eat level from the apple generator
//   head_x, head_y       - head cell (segment 0)
//   body_x, body_y       - segment i coordinate at [6i+5:6i]
//   body_valid           - bit i set when segment i is part of the snake
//   length               - current segment count (3..16)
//   game_state           - 0 IDLE, 1 PLAY, 2 DEAD
//   hit                  - one-cycle pulse on the collision that kills the snake
module snake_body_ctrl #(
  parameter int unsigned MOVE_TICKS = 12_500_000
) (
  input  logic        CLK_50M,
  input  logic        RSTn,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        add_cube,
  output logic [5:0]  head_x,
  output logic [5:0]  head_y,
  output logic [95:0] body_x,
  output logic [95:0] body_y,
  output logic [15:0] body_valid,
  output logic [4:0]  length,
  output logic [1:0]  game_state,
  output logic        hit
);

  localparam int unsigned SEGS  = 16;
  localparam int unsigned CW    = 6;
  localparam int unsigned LW    = 5;
  localparam int unsigned CNT_W = (MOVE_TICKS > 2) ? $clog2(MOVE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_TICKS - 1);

  localparam logic [CW-1:0] INIT_X [SEGS] = '{0: 6'd10, 1: 6'd9,  2: 6'd8,  default: 6'd0};
  localparam logic [CW-1:0] INIT_Y [SEGS] = '{0: 6'd10, 1: 6'd10, 2: 6'd10, default: 6'd0};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_DEAD = 2'd2} state_e;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  function automatic dir_e reverse_of(input dir_e d);
    dir_e r;
    r = DIR_LEFT;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = DIR_LEFT;
    endcase
    return r;
  endfunction

  function automatic logic [SEGS-1:0] valid_mask(input logic [LW-1:0] n);
    logic [SEGS-1:0] m;
    m = '0;
    for (int i = 0; i < SEGS; i++) m[i] = (LW'(i) < n);
    return m;
  endfunction

  state_e           state_q;
  dir_e             dir_q, next_dir_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CW-1:0]    seg_x_q [SEGS];
  logic [CW-1:0]    seg_y_q [SEGS];
  logic [LW-1:0]    len_q;
  logic [SEGS-1:0]  valid_q;
  logic             grow_pending_q;
  logic [3:0]       key_prev_q;
  logic             add_prev_q;
  logic             hit_q;

  logic [3:0]    key_vec;
  logic          key_rise, add_rise, key_any, tick, grow, wall, self_hit, collide;
  dir_e          key_dir, dir_ref;
  logic [CW-1:0] nh_x_d, nh_y_d;
  logic [LW-1:0] len_d;

  // Key/eat edge detection, steering candidate and next-head/collision evaluation
  always_comb begin
    key_vec  = {key_up, key_down, key_left, key_right};
    key_rise = |(key_vec & ~key_prev_q);
    key_any  = |key_vec;
    add_rise = add_cube & ~add_prev_q;
    key_dir  = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;
    tick = (state_q == ST_PLAY) && (cnt_q == CNT_LAST);
    // On a tick the move being executed becomes the reference for reversal checks
    dir_ref = tick ? next_dir_q : dir_q;
    nh_x_d = seg_x_q[0];
    nh_y_d = seg_y_q[0];
    case (next_dir_q)
      DIR_UP:    nh_y_d = seg_y_q[0] - 6'd1;
      DIR_DOWN:  nh_y_d = seg_y_q[0] + 6'd1;
      DIR_LEFT:  nh_x_d = seg_x_q[0] - 6'd1;
      DIR_RIGHT: nh_x_d = seg_x_q[0] + 6'd1;
      default:   nh_x_d = seg_x_q[0];
    endcase
    grow  = (grow_pending_q | add_rise) & (len_q < 5'd16);
    len_d = len_q + LW'(grow);
    wall  = (nh_x_d == 6'd0) || (nh_x_d == 6'd39) || (nh_y_d == 6'd0) || (nh_y_d == 6'd29);
    // The last old segment vacates on a non-growing move, so only j <= len_d-2 can be hit
    self_hit = 1'b0;
    for (int j = 0; j < SEGS - 1; j++) begin
      if ((LW'(j) + 5'd2 <= len_d) && (nh_x_d == seg_x_q[j]) && (nh_y_d == seg_y_q[j]))
        self_hit = 1'b1;
    end
    collide = wall | self_hit;
  end

  // Game state, move execution and all registered state
  always_ff @(posedge CLK_50M or negedge RSTn) begin
    if (!RSTn) begin
      state_q        <= ST_IDLE;
      dir_q          <= DIR_RIGHT;
      next_dir_q     <= DIR_RIGHT;
      cnt_q          <= '0;
      seg_x_q        <= INIT_X;
      seg_y_q        <= INIT_Y;
      len_q          <= 5'd3;
      valid_q        <= valid_mask(5'd3);
      grow_pending_q <= 1'b0;
      key_prev_q     <= '0;
      add_prev_q     <= 1'b0;
      hit_q          <= 1'b0;
    end else begin
      key_prev_q <= key_vec;
      add_prev_q <= add_cube;
      hit_q      <= 1'b0;
      if (key_any && (key_dir != reverse_of(dir_ref))) next_dir_q <= key_dir;
      if (add_rise) grow_pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (key_rise) state_q <= ST_PLAY;
        end
        ST_PLAY: begin
          if (tick) begin
            cnt_q          <= '0;
            dir_q          <= next_dir_q;
            grow_pending_q <= 1'b0;
            if (collide) begin
              state_q <= ST_DEAD;
              hit_q   <= 1'b1;
            end else begin
              for (int i = 1; i < SEGS; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
              end
              seg_x_q[0] <= nh_x_d;
              seg_y_q[0] <= nh_y_d;
              len_q      <= len_d;
              valid_q    <= valid_mask(len_d);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          cnt_q <= '0;
          // Restart overrides any steering or eat captured this cycle
          if (key_rise) begin
            state_q        <= ST_IDLE;
            dir_q          <= DIR_RIGHT;
            next_dir_q     <= DIR_RIGHT;
            seg_x_q        <= INIT_X;
            seg_y_q        <= INIT_Y;
            len_q          <= 5'd3;
            valid_q        <= valid_mask(5'd3);
            grow_pending_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Flatten the segment registers onto the packed output buses
  always_comb begin
    body_x = '0;
    body_y = '0;
    for (int i = 0; i < SEGS; i++) begin
      body_x[CW*i +: CW] = seg_x_q[i];
      body_y[CW*i +: CW] = seg_y_q[i];
    end
  end

  assign head_x     = seg_x_q[0];
  assign head_y     = seg_y_q[0];
  assign body_valid = valid_q;
  assign length     = len_q;
  assign game_state = state_q;
  assign hit        = hit_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Directed bench for snake_body_ctrl with MOVE_TICKS = 4: expected head/length/state
// per move are queued before each move and popped after it commits.
module tb_snake_body_ctrl;
  localparam int unsigned MT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_up, key_down, key_left, key_right, add_cube;
  logic [5:0]  head_x, head_y;
  logic [95:0] body_x, body_y;
  logic [15:0] body_valid;
  logic [4:0]  length;
  logic [1:0]  game_state;
  logic        hit;

  snake_body_ctrl #(.MOVE_TICKS(MT)) dut (
    .CLK_50M(clk), .RSTn(rst_n),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .add_cube(add_cube),
    .head_x(head_x), .head_y(head_y), .body_x(body_x), .body_y(body_y),
    .body_valid(body_valid), .length(length), .game_state(game_state), .hit(hit)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [5:0] x;
    logic [5:0] y;
    logic [4:0] len;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int x, input int y, input int len, input int st);
    exp_t e;
    e.tag = tag; e.x = 6'(x); e.y = 6'(y); e.len = 5'(len); e.st = 2'(st);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_has_entry", 96'(sb.size() != 0), 96'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_x"},   96'(head_x),     96'(e.x));
      chk({e.tag, "_y"},   96'(head_y),     96'(e.y));
      chk({e.tag, "_len"}, 96'(length),     96'(e.len));
      chk({e.tag, "_st"},  96'(game_state), 96'(e.st));
    end
  endtask

  // One move interval starting right after a commit: keys k={up,down,left,right}
  // pressed for the first cycle; optional eat pulse in the first cycle or the tick cycle.
  task automatic step(input logic [3:0] k, input bit eat_early, input bit eat_tick);
    {key_up, key_down, key_left, key_right} = k;
    if (eat_early) add_cube = 1'b1;
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = 4'b0;
    if (eat_early) add_cube = 1'b0;
    repeat (MT - 2) @(negedge clk);
    if (eat_tick) add_cube = 1'b1;
    @(negedge clk);
    if (eat_tick) add_cube = 1'b0;
  endtask

  task automatic mv(input string tag, input logic [3:0] k, input bit ee, input bit et,
                    input int x, input int y, input int len, input int st);
    push(tag, x, y, len, st);
    step(k, ee, et);
    pop_check();
  endtask

  task automatic press(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = 4'b0;
  endtask

  logic [95:0] init_bx, init_by;

  initial begin
    init_bx = '0; init_bx[5:0] = 6'd10; init_bx[11:6] = 6'd9;  init_bx[17:12] = 6'd8;
    init_by = '0; init_by[5:0] = 6'd10; init_by[11:6] = 6'd10; init_by[17:12] = 6'd10;
    {key_up, key_down, key_left, key_right} = 4'b0;
    add_cube = 1'b0;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_head_x", 96'(head_x), 96'(10));
    chk("rst_head_y", 96'(head_y), 96'(10));
    chk("rst_len",    96'(length), 96'(3));
    chk("rst_state",  96'(game_state), 96'(0));
    chk("rst_hit",    96'(hit), 96'(0));
    chk("rst_valid",  96'(body_valid), 96'h7);
    chk("rst_body_x", body_x, init_bx);
    chk("rst_body_y", body_y, init_by);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", 96'(head_x), 96'(10));

    press(4'b0001);
    chk("play_entered", 96'(game_state), 96'(1));
    mv("t1", 4'b0, 0, 0, 11, 10, 3, 1);
    mv("t2", 4'b0, 0, 0, 12, 10, 3, 1);
    mv("t3", 4'b0, 0, 0, 13, 10, 3, 1);
    mv("rev_ignored", 4'b0010, 0, 0, 14, 10, 3, 1);

    // Up, then left held through the tick: this move goes up, the next one left
    push("up_turn", 14, 9, 3, 1);
    key_up = 1'b1;
    @(negedge clk);
    key_up = 1'b0; key_left = 1'b1;
    repeat (MT - 1) @(negedge clk);
    key_left = 1'b0;
    pop_check();
    mv("left_turn", 4'b0, 0, 0, 13, 9, 3, 1);

    // add_cube held high for 20 cycles grows exactly once
    add_cube = 1'b1;
    mv("hold1", 4'b0, 0, 0, 12, 9, 4, 1);
    chk("new_tail_x", 96'(body_x[23:18]), 96'(14));
    chk("new_tail_y", 96'(body_y[23:18]), 96'(10));
    chk("valid4",     96'(body_valid), 96'hF);
    mv("hold2", 4'b0, 0, 0, 11, 9, 4, 1);
    mv("hold3", 4'b0, 0, 0, 10, 9, 4, 1);
    mv("hold4", 4'b0, 0, 0, 9,  9, 4, 1);
    mv("hold5", 4'b0, 0, 0, 8,  9, 4, 1);
    add_cube = 1'b0;

    // Tight loop at length 4: tail vacates, no collision
    mv("l4_down",  4'b0100, 0, 0, 8, 10, 4, 1);
    mv("l4_right", 4'b0001, 0, 0, 9, 10, 4, 1);
    mv("l4_up",    4'b1000, 0, 0, 9, 9,  4, 1);
    mv("eat5",     4'b0,    1, 0, 9, 8,  5, 1);
    // Same loop at length 5: head re-enters segment 3
    mv("l5_right", 4'b0001, 0, 0, 10, 8, 5, 1);
    mv("l5_down",  4'b0100, 0, 0, 10, 9, 5, 1);
    mv("l5_left",  4'b0010, 0, 0, 10, 9, 5, 2);
    chk("self_hit_pulse", 96'(hit), 96'(1));
    @(negedge clk);
    chk("self_hit_clear", 96'(hit), 96'(0));
    repeat (4) @(negedge clk);
    chk("dead_frozen_x", 96'(head_x), 96'(10));
    chk("dead_frozen_y", 96'(head_y), 96'(9));

    press(4'b0100);
    chk("restart_state", 96'(game_state), 96'(0));
    chk("restart_x",     96'(head_x), 96'(10));
    chk("restart_y",     96'(head_y), 96'(10));
    chk("restart_len",   96'(length), 96'(3));
    chk("restart_valid", 96'(body_valid), 96'h7);
    chk("restart_bx",    body_x, init_bx);
    repeat (6) @(negedge clk);
    chk("idle_frozen_x", 96'(head_x), 96'(10));
    chk("idle_frozen_st", 96'(game_state), 96'(0));

    // Run right into the x=39 wall
    press(4'b0001);
    for (int i = 11; i <= 38; i++) mv($sformatf("run%0d", i), 4'b0, 0, 0, i, 10, 3, 1);
    mv("wall", 4'b0, 0, 0, 38, 10, 3, 2);
    chk("wall_hit_pulse", 96'(hit), 96'(1));
    @(negedge clk);
    chk("wall_hit_clear", 96'(hit), 96'(0));
    press(4'b1000);
    chk("restart2_state", 96'(game_state), 96'(0));
    chk("restart2_x",     96'(head_x), 96'(10));
    chk("restart2_len",   96'(length), 96'(3));

    // Grow to 16 with eat edges landing on the tick cycle, then eat at full length
    repeat (2) @(negedge clk);
    press(4'b0001);
    for (int n = 1; n <= 13; n++) mv($sformatf("grow%0d", n), 4'b0, 0, 1, 10 + n, 10, 3 + n, 1);
    chk("valid16", 96'(body_valid), 96'hFFFF);
    mv("full_eat",   4'b0, 1, 0, 24, 10, 16, 1);
    mv("full_after", 4'b0, 0, 0, 25, 10, 16, 1);
    chk("valid16_kept", 96'(body_valid), 96'hFFFF);

    // Asynchronous reset in the middle of a move interval
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_head_x", 96'(head_x), 96'(10));
    chk("arst_head_y", 96'(head_y), 96'(10));
    chk("arst_len",    96'(length), 96'(3));
    chk("arst_state",  96'(game_state), 96'(0));
    chk("arst_hit",    96'(hit), 96'(0));
    chk("arst_valid",  96'(body_valid), 96'h7);
    chk("arst_body_x", body_x, init_bx);
    chk("arst_body_y", body_y, init_by);
    chk("sb_drained",  96'(sb.size()), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
